button_pulse_conditioner: RTL and testbench

//   Upstream input stage of the tic-tac-toe top level.

---
 rtl/button_pulse_conditioner_if.sv | 23 ++
 rtl/button_pulse_conditioner.sv | 64 ++++++
 tb/tb_button_pulse_conditioner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/button_pulse_conditioner_if.sv
// Button bundle between the board pins and the game logic: raw active-low inputs in,
// debounced levels and single-cycle press pulses out.
interface button_pulse_conditioner_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] btn_n;
  logic [N_BTN-1:0] btn_level;
  logic             I_p;
  logic             T_p;
  logic             W_p;
  logic             A_p;
  logic             any_p;

  modport master (
    output btn_n,
    input  btn_level, I_p, T_p, W_p, A_p, any_p
  );

  modport slave (
    input  btn_n,
    output btn_level, I_p, T_p, W_p, A_p, any_p
  );
endinterface

// File: rtl/button_pulse_conditioner.sv
// Per-button synchroniser, debouncer and press-edge pulser for the four board buttons
// (bit0=I select, bit1=T restart, bit2=W confirm, bit3=A auxiliary).
module button_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned N_BTN           = 4
) (
  input logic                        clk,
  input logic                        rst,
  button_pulse_conditioner_if.slave  bus
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]            sync1_q, sync2_q;
  logic [N_BTN-1:0]            level_q, level_d;
  logic [N_BTN-1:0]            pulse_q, pulse_d;
  logic [N_BTN-1:0]            s;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  assign s = ~sync2_q;

  // Any sample matching the accepted level restarts the count; a level is accepted only
  // after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    pulse_d = '0;
    cnt_d   = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s[i];
          pulse_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= bus.btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.btn_level = level_q;
  assign bus.I_p       = pulse_q[0];
  assign bus.T_p       = pulse_q[1];
  assign bus.W_p       = pulse_q[2];
  assign bus.A_p       = pulse_q[3];
  assign bus.any_p     = |pulse_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner: directed scenarios with literal expectations plus
// randomized bouncing checked every cycle against a sliding-window reference model.
module tb_button_pulse_conditioner;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  button_pulse_conditioner_if #(.N_BTN(4)) bus ();

  button_pulse_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .N_BTN          (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the level used at edge n is ~btn_n sampled at edge n-2 (released before
  // reset ends); a level flips when the last D samples since reset all disagree with it.
  logic [3:0] raw [$]    = '{4'hF, 4'hF};
  logic [3:0] s_hist [$];
  logic [3:0] m_level    = '0;
  logic [3:0] m_pulse    = '0;

  initial begin
    logic [3:0] s_now;
    bit         all_diff;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        raw     = '{4'hF, 4'hF};
        s_hist  = {};
        m_level = '0;
        m_pulse = '0;
      end else begin
        s_now = ~raw[0];
        void'(raw.pop_front());
        raw.push_back(bus.btn_n);
        s_hist.push_back(s_now);
        if (s_hist.size() > D) void'(s_hist.pop_front());
        m_pulse = '0;
        for (int c = 0; c < 4; c++) begin
          all_diff = (s_hist.size() == D);
          foreach (s_hist[j]) if (s_hist[j][c] == m_level[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[c] = ~m_level[c];
            m_pulse[c] = m_level[c];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("model_compare",
          {23'd0, bus.btn_level, bus.A_p, bus.W_p, bus.T_p, bus.I_p, bus.any_p},
          {23'd0, m_level, m_pulse, |m_pulse});
    end
  end

  function automatic logic [3:0] pulses();
    return {bus.A_p, bus.W_p, bus.T_p, bus.I_p};
  endfunction

  initial begin
    int npulse;
    int rem [4];

    rst        = 1'b1;
    bus.btn_n  = 4'hF;
    #1;
    rst        = 1'b0;
    bus.btn_n  = 4'h0;

    // Reset holds everything quiet even with all buttons pressed
    repeat (3) begin
      @(negedge clk);
      chk("reset_level", {28'd0, bus.btn_level}, 32'd0);
      chk("reset_pulses", {27'd0, pulses(), bus.any_p}, 32'd0);
    end
    bus.btn_n = 4'hF;
    #2 rst = 1'b1;
    repeat (10) @(negedge clk);

    // Clean W press
    bus.btn_n[2] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("clean_W_p", {31'd0, bus.W_p}, {31'd0, i == 5});
      chk("clean_level2", {31'd0, bus.btn_level[2]}, {31'd0, i >= 5});
    end
    bus.btn_n = 4'hF;
    repeat (10) @(negedge clk);

    // Bouncing I, then steady low
    for (int i = 0; i < 10; i++) begin
      bus.btn_n[0] = (i % 2 == 1);
      @(negedge clk);
      chk("bounce_I_quiet", {31'd0, bus.I_p}, 32'd0);
    end
    bus.btn_n[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bounce_I_p", {31'd0, bus.I_p}, {31'd0, i == 5});
    end
    bus.btn_n = 4'hF;
    repeat (10) @(negedge clk);

    // Simultaneous I and W
    bus.btn_n = 4'b1010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("simul_pulses", {28'd0, pulses()}, (i == 5) ? 32'b0101 : 32'd0);
      chk("simul_any", {31'd0, bus.any_p}, {31'd0, i == 5});
    end
    bus.btn_n = 4'hF;
    repeat (10) @(negedge clk);

    // T press, release, press
    npulse = 0;
    bus.btn_n[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      npulse += int'(bus.T_p);
    end
    bus.btn_n[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      npulse += int'(bus.T_p);
      chk("release_level1", {31'd0, bus.btn_level[1]}, {31'd0, i < 5});
    end
    bus.btn_n[1] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      npulse += int'(bus.T_p);
    end
    bus.btn_n[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      npulse += int'(bus.T_p);
    end
    chk("T_pulse_count", npulse, 32'd2);

    // Reset with A's count at 2, release while still held
    bus.btn_n[3] = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midreset_A_p", {31'd0, bus.A_p}, 32'd0);
    chk("midreset_level", {28'd0, bus.btn_level}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_A_p", {31'd0, bus.A_p}, {31'd0, i == 5});
    end
    bus.btn_n = 4'hF;
    repeat (10) @(negedge clk);

    // Randomized bouncing on all channels with occasional resets
    for (int c = 0; c < 4; c++) rem[c] = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        if (rem[c] == 0) begin
          bus.btn_n[c] = ~bus.btn_n[c];
          rem[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 12));
        end
        rem[c]--;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
